// File: rtl/multimode_shift_reg_pkg.sv
// Shared definitions for the multimode shift register: operation encodings and FSM states.
package multimode_shift_reg_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_LOAD  = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_ROL   = 3'b101;
    localparam logic [2:0] MODE_ASR   = 3'b110;
    localparam logic [2:0] MODE_BURST = 3'b111;

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

    // Bit counter width; a 2-bit register still needs one counter bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/multimode_shift_reg_if.sv
// Operation, parallel and serial-handshake signals of the multimode shift register.
interface multimode_shift_reg_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STEP_W = 3
) ();

    logic              en;
    logic [2:0]        mode;
    logic [STEP_W-1:0] amt;
    logic [WIDTH-1:0]  p_din;
    logic              s_left_din;
    logic              s_right_din;
    logic              ser_ready;
    logic              abort;
    logic [WIDTH-1:0]  p_dout;
    logic              s_left_dout;
    logic              s_right_dout;
    logic              ser_dout;
    logic              ser_valid;
    logic              busy;
    logic              done;

    modport master (
        output en, mode, amt, p_din, s_left_din, s_right_din, ser_ready, abort,
        input  p_dout, s_left_dout, s_right_dout, ser_dout, ser_valid, busy, done
    );

    modport slave (
        input  en, mode, amt, p_din, s_left_din, s_right_din, ser_ready, abort,
        output p_dout, s_left_dout, s_right_dout, ser_dout, ser_valid, busy, done
    );

endinterface

// File: rtl/multimode_shift_reg_shift_rotate_unit.sv
// Combinational shifter: next register value for the shift, rotate and arithmetic-shift modes.
module shift_rotate_unit
    import multimode_shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STEP_W = 3
) (
    input  logic [WIDTH-1:0]  data,
    input  logic [STEP_W-1:0] amt,
    input  logic [2:0]        mode,
    input  logic              fill_left,
    input  logic              fill_right,
    output logic [WIDTH-1:0]  result
);

    int unsigned        shamt;
    int unsigned        rot;
    logic               fill_r;
    logic [2*WIDTH-1:0] wide;

    always_comb begin
        // Saturating at WIDTH pushes the whole word out, leaving only fill bits.
        shamt = 32'(amt);
        if (shamt > WIDTH) begin
            shamt = WIDTH;
        end
        rot    = 32'(amt) % WIDTH;
        fill_r = (mode == MODE_ASR) ? data[WIDTH-1] : fill_right;
        wide   = '0;
        result = data;
        case (mode)
            MODE_SHR, MODE_ASR: begin
                wide   = {{WIDTH{fill_r}}, data} >> shamt;
                result = wide[WIDTH-1:0];
            end
            MODE_SHL: begin
                wide   = {data, {WIDTH{fill_left}}} << shamt;
                result = wide[2*WIDTH-1:WIDTH];
            end
            MODE_ROR: begin
                wide   = {data, data} >> rot;
                result = wide[WIDTH-1:0];
            end
            MODE_ROL: begin
                wide   = {data, data} << rot;
                result = wide[2*WIDTH-1:WIDTH];
            end
            default: result = data;
        endcase
    end

endmodule

// File: rtl/multimode_shift_reg.sv
// Multimode shift register: shifts, rotates, parallel load and a handshaked LSB-first burst-out.
module multimode_shift_reg
    import multimode_shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STEP_W = 3
) (
    input logic                    clk,
    input logic                    rst,
    multimode_shift_reg_if.slave   bus
);

    localparam int unsigned     CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] data_q;
    logic [CntW-1:0]  cnt_q;
    logic             done_q;
    logic [WIDTH-1:0] sru_result;

    shift_rotate_unit #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_sru (
        .data       (data_q),
        .amt        (bus.amt),
        .mode       (bus.mode),
        .fill_left  (bus.s_left_din),
        .fill_right (bus.s_right_din),
        .result     (sru_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.en) begin
                        case (bus.mode)
                            MODE_HOLD: ;
                            MODE_LOAD: data_q <= bus.p_din;
                            MODE_BURST: begin
                                data_q  <= bus.p_din;
                                cnt_q   <= '0;
                                state_q <= StBusy;
                            end
                            default: data_q <= sru_result;
                        endcase
                    end
                end
                StBusy: begin
                    // Abort beats a same-cycle ready: the word is left exactly as it was.
                    if (bus.abort) begin
                        state_q <= StIdle;
                    end else if (bus.ser_ready) begin
                        data_q <= {bus.s_right_din, data_q[WIDTH-1:1]};
                        if (cnt_q == LastBit) begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.p_dout       = data_q;
    assign bus.s_left_dout  = data_q[WIDTH-1];
    assign bus.s_right_dout = data_q[0];
    assign bus.busy         = (state_q == StBusy);
    assign bus.ser_valid    = (state_q == StBusy);
    assign bus.ser_dout     = (state_q == StBusy) & data_q[0];
    assign bus.done         = done_q;

endmodule

// File: tb/tb_multimode_shift_reg.sv
// Directed bench for multimode_shift_reg with a per-cycle behavioural reference model.
module tb_multimode_shift_reg;
    import multimode_shift_reg_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned SW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    multimode_shift_reg_if #(.WIDTH(W), .STEP_W(SW)) bus ();

    multimode_shift_reg #(.WIDTH(W), .STEP_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: bitwise definitions of each operation.
    function automatic logic [W-1:0] shr_model(input logic [W-1:0] v, input int n,
                                               input logic fill);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            r[i] = (i + n < W) ? v[i + n] : fill;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] shl_model(input logic [W-1:0] v, input int n,
                                               input logic fill);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            r[i] = (i - n >= 0) ? v[i - n] : fill;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] ror_model(input logic [W-1:0] v, input int n);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            r[i] = v[(i + n) % W];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rol_model(input logic [W-1:0] v, input int n);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            r[i] = v[(i + W - (n % W)) % W];
        end
        return r;
    endfunction

    logic [W-1:0] m_data   = '0;
    bit           m_busy   = 1'b0;
    bit           m_done   = 1'b0;
    int           m_sent   = 0;
    bit           model_ok = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_data   = '0;
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_sent   = 0;
            model_ok = 1'b1;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (bus.en) begin
                    case (bus.mode)
                        MODE_SHR: m_data = shr_model(m_data, int'(bus.amt), bus.s_right_din);
                        MODE_SHL: m_data = shl_model(m_data, int'(bus.amt), bus.s_left_din);
                        MODE_LOAD: m_data = bus.p_din;
                        MODE_ROR: m_data = ror_model(m_data, int'(bus.amt));
                        MODE_ROL: m_data = rol_model(m_data, int'(bus.amt));
                        MODE_ASR: m_data = shr_model(m_data, int'(bus.amt), m_data[W-1]);
                        MODE_BURST: begin
                            m_data = bus.p_din;
                            m_sent = 0;
                            m_busy = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end else if (bus.abort) begin
                m_busy = 1'b0;
            end else if (bus.ser_ready) begin
                m_data = shr_model(m_data, 1, bus.s_right_din);
                m_sent++;
                if (m_sent == W) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("p_dout", bus.p_dout, m_data);
            check("busy", bus.busy, m_busy);
            check("ser_valid", bus.ser_valid, m_busy);
            check("done", bus.done, m_done);
            check("s_left_dout", bus.s_left_dout, m_data[W-1]);
            check("s_right_dout", bus.s_right_dout, m_data[0]);
            if (m_busy) check("ser_dout", bus.ser_dout, m_data[0]);
        end
    end

    task automatic op(input logic [2:0] mode, input logic [SW-1:0] amt, input logic [W-1:0] din,
                      input logic sl, input logic sr);
        bus.en          = 1'b1;
        bus.mode        = mode;
        bus.amt         = amt;
        bus.p_din       = din;
        bus.s_left_din  = sl;
        bus.s_right_din = sr;
        @(negedge clk);
        bus.en = 1'b0;
    endtask

    // Returns at the negedge after the burst ends (the done cycle for a full burst).
    task automatic run_burst(input logic [W-1:0] d, input int stall_bit, input int stop_bit,
                             input bit use_rst, input bit poke, output int nvalid,
                             output logic [W-1:0] got);
        bit stalled = 1'b0;
        int k       = 0;
        nvalid = 0;
        got    = '0;
        bus.en          = 1'b1;
        bus.mode        = MODE_BURST;
        bus.p_din       = d;
        bus.s_right_din = 1'b0;
        bus.ser_ready   = 1'b1;
        bus.abort       = 1'b0;
        @(negedge clk);
        check("burst_start_busy", bus.busy, 1);
        if (poke) begin
            bus.mode  = MODE_LOAD;
            bus.p_din = 8'hFF;
        end else begin
            bus.en = 1'b0;
        end
        for (int c = 0; c < 20; c++) begin
            if (!bus.busy) break;
            nvalid++;
            bus.ser_ready = !(k == stall_bit && !stalled);
            if (k == stall_bit) stalled = 1'b1;
            bus.abort = (k == stop_bit) && !use_rst;
            rst       = (k == stop_bit) && use_rst;
            if (bus.ser_ready && k != stop_bit && k < W) begin
                got[k] = bus.ser_dout;
                k++;
            end
            @(negedge clk);
            bus.abort = 1'b0;
            rst       = 1'b0;
        end
        check("burst_terminates", bus.busy, 0);
        bus.en        = 1'b0;
        bus.ser_ready = 1'b1;
    endtask

    int           nv;
    logic [W-1:0] got;

    initial begin
        bus.en          = 1'($urandom);
        bus.mode        = 3'($urandom);
        bus.amt         = SW'($urandom);
        bus.p_din       = W'($urandom);
        bus.s_left_din  = 1'($urandom);
        bus.s_right_din = 1'($urandom);
        bus.ser_ready   = 1'($urandom);
        bus.abort       = 1'($urandom);
        repeat (2) @(negedge clk);
        check("reset_p_dout", bus.p_dout, 8'h00);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        rst           = 1'b0;
        bus.en        = 1'b0;
        bus.abort     = 1'b0;
        bus.ser_ready = 1'b1;

        op(MODE_LOAD, 3'd0, 8'hA5, 1'b0, 1'b0); check("load_a5", bus.p_dout, 8'hA5);
        op(MODE_SHR, 3'd3, 8'h00, 1'b0, 1'b1); check("shr3_fill1", bus.p_dout, 8'hF4);
        op(MODE_LOAD, 3'd0, 8'hA5, 1'b0, 1'b0);
        op(MODE_SHL, 3'd2, 8'h00, 1'b0, 1'b1); check("shl2_fill0", bus.p_dout, 8'h94);
        op(MODE_SHR, 3'd0, 8'h00, 1'b1, 1'b1); check("shr_amt0", bus.p_dout, 8'h94);
        bus.mode  = MODE_LOAD;
        bus.p_din = 8'h33;
        @(negedge clk); check("idle_en0_hold", bus.p_dout, 8'h94);
        op(MODE_HOLD, 3'd5, 8'h33, 1'b1, 1'b1); check("mode_hold", bus.p_dout, 8'h94);
        op(MODE_LOAD, 3'd0, 8'h81, 1'b0, 1'b0);
        op(MODE_ROL, 3'd1, 8'h00, 1'b1, 1'b1); check("rol1", bus.p_dout, 8'h03);
        op(MODE_LOAD, 3'd0, 8'h81, 1'b0, 1'b0);
        op(MODE_ROR, 3'd3, 8'h00, 1'b1, 1'b1); check("ror3", bus.p_dout, 8'h30);
        op(MODE_LOAD, 3'd0, 8'h81, 1'b0, 1'b0);
        op(MODE_ROR, 3'd7, 8'h00, 1'b0, 1'b0); check("ror7", bus.p_dout, 8'h03);
        op(MODE_LOAD, 3'd0, 8'h90, 1'b0, 1'b0);
        op(MODE_ASR, 3'd2, 8'h00, 1'b0, 1'b0); check("asr2", bus.p_dout, 8'hE4);
        op(MODE_LOAD, 3'd0, 8'h90, 1'b0, 1'b0);
        op(MODE_ASR, 3'd7, 8'h00, 1'b0, 1'b0); check("asr7", bus.p_dout, 8'hFF);
        op(MODE_LOAD, 3'd0, 8'hA5, 1'b0, 1'b0);
        op(MODE_SHR, 3'd7, 8'h00, 1'b1, 1'b0); check("shr7", bus.p_dout, 8'h01);
        op(MODE_LOAD, 3'd0, 8'hA5, 1'b0, 1'b0);
        op(MODE_SHL, 3'd7, 8'h00, 1'b0, 1'b1); check("shl7", bus.p_dout, 8'h80);

        // Full burst while en/mode try to reload mid-burst.
        run_burst(8'hB4, -1, -1, 1'b0, 1'b1, nv, got);
        check("burst_valid_cycles", nv, 8);
        check("burst_bits", got, 8'hB4);
        check("burst_done", bus.done, 1);
        check("burst_final", bus.p_dout, 8'h00);

        // Started in the done cycle, with a one-cycle stall at bit 3.
        run_burst(8'hB4, 3, -1, 1'b0, 1'b0, nv, got);
        check("stall_valid_cycles", nv, 9);
        check("stall_bits", got, 8'hB4);
        check("stall_done", bus.done, 1);
        @(negedge clk); check("done_one_cycle", bus.done, 0);

        run_burst(8'hB4, -1, 4, 1'b0, 1'b0, nv, got);
        check("abort_done", bus.done, 0);
        check("abort_p_dout", bus.p_dout, 8'h0B);
        @(negedge clk); check("abort_no_late_done", bus.done, 0);

        run_burst(8'hB4, -1, 4, 1'b1, 1'b0, nv, got);
        check("rst_burst_p_dout", bus.p_dout, 8'h00);
        check("rst_burst_done", bus.done, 0);

        bus.abort = 1'b1;
        op(MODE_LOAD, 3'd0, 8'h5A, 1'b0, 1'b0); check("abort_ignored_idle", bus.p_dout, 8'h5A);
        bus.abort = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multimode_shift_reg.md
Name: multimode_shift_reg

Overview:
Parametrised successor to the team's universal shift register. It adds multi-position shifts, rotates, arithmetic shift right and a handshaked serial burst-out mode. Used as a general datapath shifter and as a parallel-to-serial converter feeding serial links.

Parameters:
WIDTH, 8, register width in bits; must be >= 2.
STEP_W, 3, width of shift-amount input; maximum amount is 2**STEP_W-1.

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  operation strobe; sampled only in IDLE
mode  in  3  operation select; encodings in Behaviour
amt  in  STEP_W  shift/rotate distance for modes 001-110
p_din  in  WIDTH  parallel load data
s_left_din  in  1  fill bit for left shifts
s_right_din  in  1  fill bit for right shifts and burst
ser_ready  in  1  downstream ready during burst
abort  in  1  terminates a burst
p_dout  out  WIDTH  register contents (registered)
s_left_dout  out  1  p_dout[WIDTH-1]
s_right_dout  out  1  p_dout[0]
ser_dout  out  1  p_dout[0] while ser_valid
ser_valid  out  1  high in BUSY
busy  out  1  high in BUSY
done  out  1  registered one-cycle pulse at burst completion

Behaviour:
- Reset (rst=1 at an edge): p_dout=0, state=IDLE, bit counter=0, done=0. Reset wins over every other input, including mid-burst.
- State machine: IDLE and BUSY. In IDLE with en=0, p_dout holds.
- Modes in IDLE with en=1. Result appears on p_dout the next cycle (latency 1).
  - 000: hold.
  - 001: shift right by amt; the vacated top amt bits take s_right_din.
  - 010: shift left by amt; the vacated low amt bits take s_left_din.
  - 011: p_dout <= p_din.
  - 100: rotate right by amt mod WIDTH.
  - 101: rotate left by amt mod WIDTH.
  - 110: arithmetic shift right by amt; vacated bits take the old p_dout[WIDTH-1].
  - 111: start burst. p_dout <= p_din, counter <= 0, state -> BUSY.
- amt=0 in modes 001-110: no change. For shifts, amt >= WIDTH means every bit becomes the fill bit (or sign bit for 110).
- BUSY:
  - ser_valid=busy=1 and ser_dout=p_dout[0], so bits go out LSB first.
  - On each edge with ser_ready=1: p_dout shifts right by 1 with s_right_din fill, and counter increments.
  - ser_ready=0: p_dout and counter hold, so ser_dout stays stable (valid/ready stall).
  - Transfer completes on the edge where ser_ready=1 and counter==WIDTH-1: state -> IDLE, done=1 for the following cycle only.
  - en and mode are ignored throughout BUSY.
- abort=1 in BUSY (and rst=0): on that edge state -> IDLE. p_dout keeps its pre-edge value and no shift occurs, even if ser_ready=1. No done pulse. abort is ignored in IDLE.
- Exactly WIDTH accepted bits per burst. The counter is ceil(log2(WIDTH)) bits wide and never wraps past WIDTH-1.
- Back-to-back bursts: a new burst can start in the cycle done is high (state is already IDLE).

Decomposition:
- Shared package: mode encoding constants (MODE_HOLD … MODE_BURST) and the IDLE/BUSY state enum.
- One combinational sub-module, shift_rotate_unit (WIDTH, STEP_W). Inputs: data, amt, mode, fill bits. Output: next value for modes 001-110.
- The top level holds the register, FSM, counter and done flop.

Test Plan:
- rst=1 with random inputs -> p_dout=0x00, busy=0, done=0. Then mode 011, p_din=0xA5, en=1 -> p_dout=0xA5 one cycle later.
- From 0xA5: mode 001, amt=3, s_right_din=1 -> 0xF4. From 0xA5: mode 010, amt=2, s_left_din=0 -> 0x94. amt=0 -> unchanged.
- From 0x81: mode 101, amt=1 -> 0x03. From 0x81: mode 100, amt=3 -> 0x30. From 0x90: mode 110, amt=2 -> 0xE4. From 0x90: mode 110, amt=7 -> 0xFF.
- Burst with p_din=0xB4, ser_ready=1, s_right_din=0 -> ser_valid for 8 cycles carrying 0,0,1,0,1,1,0,1, then done=1 for one cycle, final p_dout=0x00. Repeat with ser_ready=0 for one cycle at bit 3 -> 9 valid cycles, bit 3 held for two cycles, same sequence.
- Burst 0xB4 with abort=1 after 4 accepted bits -> busy=0 next cycle, no done pulse, p_dout=0x0B. Repeat with rst=1 instead -> p_dout=0x00, busy=0.
- During BUSY, drive en=1, mode=011 -> ignored and the burst completes normally. Start a new burst in the done cycle -> accepted, busy=1 next cycle.
